// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file writeback path.
package regfile_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;

    // One queued writeback: destination register and the value to write.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] reg_idx;
        logic [REG_DATA_W-1:0] data;
    } wr_req_t;

    // Encoding doubles as the one-hot {B,A} value driven on Granted.
    typedef enum logic [1:0] {
        GRANT_NONE = 2'b00,
        GRANT_A    = 2'b01,
        GRANT_B    = 2'b10
    } grant_src_e;

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous writeback FIFO. Besides the head entry it exposes the
// valid flag and destination of every slot so the owner can build a
// pending-register mask without peeking into the storage itself.
module wb_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int DEPTH      = 2
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 push,
    input  logic [ADDR_WIDTH-1:0]                pushReg,
    input  logic [DATA_WIDTH-1:0]                pushData,
    input  logic                                 pop,
    output logic                                 full,
    output logic                                 empty,
    output logic [ADDR_WIDTH-1:0]                headReg,
    output logic [DATA_WIDTH-1:0]                headData,
    output logic [DEPTH-1:0]                     entryValid,
    output logic [DEPTH-1:0][ADDR_WIDTH-1:0]     entryDest
);

    // One extra pointer bit distinguishes full from empty when the
    // index bits are equal; the pointers simply wrap.
    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    logic [PTR_W-1:0]                 wrPtr;
    logic [PTR_W-1:0]                 rdPtr;
    logic [PTR_W-1:0]                 count;
    logic [DEPTH-1:0][ADDR_WIDTH-1:0] regMem;
    logic [DEPTH-1:0][DATA_WIDTH-1:0] dataMem;
    logic                             doPush;
    logic                             doPop;

    assign count    = wrPtr - rdPtr;
    assign full     = (count == PTR_W'(DEPTH));
    assign empty    = (count == '0);
    assign doPush   = push && !full;
    assign doPop    = pop && !empty;
    assign headReg  = regMem[rdPtr[IDX_W-1:0]];
    assign headData = dataMem[rdPtr[IDX_W-1:0]];
    assign entryDest = regMem;

    // Pointer state: cleared on reset, advanced independently by push and pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + PTR_W'(1);
            end
            if (doPop) begin
                rdPtr <= rdPtr + PTR_W'(1);
            end
        end
    end

    // Entry storage: payload only, validity lives entirely in the pointers.
    always_ff @(posedge clk) begin
        if (doPush) begin
            regMem[wrPtr[IDX_W-1:0]]  <= pushReg;
            dataMem[wrPtr[IDX_W-1:0]] <= pushData;
        end
    end

    // A slot is live when its distance from the read pointer is below the fill count.
    always_comb begin
        logic [IDX_W-1:0] offset;
        offset     = '0;
        entryValid = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offset        = IDX_W'(i) - rdPtr[IDX_W-1:0];
            entryValid[i] = ({1'b0, offset} < count);
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between the ALU writeback (A) and
// the load writeback (B). Each side queues into its own FIFO; a round-robin
// arbiter drains the heads into a registered write stage, and a mask of
// registers with writes still in flight is exported for decode stalls.
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = REG_DATA_W,
    parameter int ADDR_WIDTH = REG_ADDR_W,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     A_Valid,
    output logic                     A_Ready,
    input  logic [ADDR_WIDTH-1:0]    A_Reg,
    input  logic [DATA_WIDTH-1:0]    A_Data,
    input  logic                     B_Valid,
    output logic                     B_Ready,
    input  logic [ADDR_WIDTH-1:0]    B_Reg,
    input  logic [DATA_WIDTH-1:0]    B_Data,
    output logic                     RegWrite,
    output logic [ADDR_WIDTH-1:0]    WriteRegister,
    output logic [DATA_WIDTH-1:0]    WriteData,
    output logic [2**ADDR_WIDTH-1:0] PendingMask,
    output logic [1:0]               Granted
);

    localparam int NUM_REGS = 2**ADDR_WIDTH;

    logic                                  aPush;
    logic                                  aPop;
    logic                                  aFull;
    logic                                  aEmpty;
    logic [ADDR_WIDTH-1:0]                 aHeadReg;
    logic [DATA_WIDTH-1:0]                 aHeadData;
    logic [FIFO_DEPTH-1:0]                 aEntryValid;
    logic [FIFO_DEPTH-1:0][ADDR_WIDTH-1:0] aEntryDest;

    logic                                  bPush;
    logic                                  bPop;
    logic                                  bFull;
    logic                                  bEmpty;
    logic [ADDR_WIDTH-1:0]                 bHeadReg;
    logic [DATA_WIDTH-1:0]                 bHeadData;
    logic [FIFO_DEPTH-1:0]                 bEntryValid;
    logic [FIFO_DEPTH-1:0][ADDR_WIDTH-1:0] bEntryDest;

    grant_src_e                            grant;
    logic                                  favorB;
    logic                                  contested;
    logic [NUM_REGS-1:0]                   pendingNext;

    // Ready depends only on FIFO occupancy, never on the requester's Valid.
    assign A_Ready = !aFull;
    assign B_Ready = !bFull;

    // Writes to register 0 complete the handshake but are dropped here,
    // so they never reach the write port or the pending mask.
    assign aPush = A_Valid && !aFull && (A_Reg != '0);
    assign bPush = B_Valid && !bFull && (B_Reg != '0);

    assign aPop = (grant == GRANT_A);
    assign bPop = (grant == GRANT_B);

    wb_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) aFifo (
        .clk        (Clk),
        .reset      (Reset),
        .push       (aPush),
        .pushReg    (A_Reg),
        .pushData   (A_Data),
        .pop        (aPop),
        .full       (aFull),
        .empty      (aEmpty),
        .headReg    (aHeadReg),
        .headData   (aHeadData),
        .entryValid (aEntryValid),
        .entryDest  (aEntryDest)
    );

    wb_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) bFifo (
        .clk        (Clk),
        .reset      (Reset),
        .push       (bPush),
        .pushReg    (B_Reg),
        .pushData   (B_Data),
        .pop        (bPop),
        .full       (bFull),
        .empty      (bEmpty),
        .headReg    (bHeadReg),
        .headData   (bHeadData),
        .entryValid (bEntryValid),
        .entryDest  (bEntryDest)
    );

    assign contested = !aEmpty && !bEmpty;

    // Grant selection on pre-edge FIFO heads; a same-cycle push is never eligible.
    always_comb begin
        grant = GRANT_NONE;
        if (contested) begin
            grant = favorB ? GRANT_B : GRANT_A;
        end else if (!aEmpty) begin
            grant = GRANT_A;
        end else if (!bEmpty) begin
            grant = GRANT_B;
        end
    end

    // Round-robin pointer: moves to the loser only when both sides competed.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            favorB <= 1'b0;
        end else if (contested) begin
            favorB <= (grant == GRANT_A);
        end
    end

    // Registered write stage; index and data hold their last values when idle.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            RegWrite      <= 1'b0;
            WriteRegister <= '0;
            WriteData     <= '0;
            Granted       <= GRANT_NONE;
        end else begin
            RegWrite <= (grant != GRANT_NONE);
            Granted  <= grant;
            case (grant)
                GRANT_A: begin
                    WriteRegister <= aHeadReg;
                    WriteData     <= aHeadData;
                end
                GRANT_B: begin
                    WriteRegister <= bHeadReg;
                    WriteData     <= bHeadData;
                end
                default: begin
                end
            endcase
        end
    end

    // Pending mask: every live FIFO slot plus the write currently on the port.
    always_comb begin
        pendingNext = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (aEntryValid[i]) begin
                pendingNext[aEntryDest[i]] = 1'b1;
            end
            if (bEntryValid[i]) begin
                pendingNext[bEntryDest[i]] = 1'b1;
            end
        end
        if (RegWrite) begin
            pendingNext[WriteRegister] = 1'b1;
        end
        pendingNext[0] = 1'b0;
    end

    assign PendingMask = pendingNext;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomised and directed bench for regfile_write_arbiter against a
// queue-based reference model.
module tb_regfile_write_arbiter;
    import regfile_pkg::*;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int DEPTH = 2;
    localparam int NREG = 32;

    logic          Clk = 1'b0;
    logic          Reset = 1'b1;
    logic          A_Valid = 1'b0;
    logic          A_Ready;
    logic [AW-1:0] A_Reg = '0;
    logic [DW-1:0] A_Data = '0;
    logic          B_Valid = 1'b0;
    logic          B_Ready;
    logic [AW-1:0] B_Reg = '0;
    logic [DW-1:0] B_Data = '0;
    logic          RegWrite;
    logic [AW-1:0] WriteRegister;
    logic [DW-1:0] WriteData;
    logic [NREG-1:0] PendingMask;
    logic [1:0]    Granted;

    regfile_write_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH)) dut (
        .Clk(Clk), .Reset(Reset),
        .A_Valid(A_Valid), .A_Ready(A_Ready), .A_Reg(A_Reg), .A_Data(A_Data),
        .B_Valid(B_Valid), .B_Ready(B_Ready), .B_Reg(B_Reg), .B_Data(B_Data),
        .RegWrite(RegWrite), .WriteRegister(WriteRegister), .WriteData(WriteData),
        .PendingMask(PendingMask), .Granted(Granted)
    );

    always #5 Clk = ~Clk;

    int nTests = 0;
    int nFail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic wr_req_t mk(input int r, input logic [31:0] d);
        wr_req_t e;
        e.reg_idx = AW'(r);
        e.data = d;
        return e;
    endfunction

    // ---------------- reference model ----------------
    wr_req_t   qa[$];
    wr_req_t   qb[$];
    bit        favB = 0;
    bit        mRegWrite = 0;
    logic [AW-1:0] mWReg = '0;
    logic [DW-1:0] mWData = '0;
    logic [1:0] mGranted = 2'b00;
    logic [DW-1:0] refRf [NREG];
    logic [DW-1:0] dutRf [NREG];
    bit        checkEn = 0;

    always @(posedge Clk) begin : model
        bit ra;
        bit rb;
        int g;
        wr_req_t e;
        if (mRegWrite) refRf[mWReg] = mWData;
        if (Reset) begin
            qa.delete();
            qb.delete();
            favB = 0;
            mRegWrite = 0;
            mWReg = '0;
            mWData = '0;
            mGranted = 2'b00;
            checkEn = 1;
        end else begin
            ra = (qa.size() < DEPTH);
            rb = (qb.size() < DEPTH);
            g = 0;
            if (qa.size() > 0 && qb.size() > 0) begin
                g = favB ? 2 : 1;
                favB = !favB;
            end else if (qa.size() > 0) begin
                g = 1;
            end else if (qb.size() > 0) begin
                g = 2;
            end
            if (g == 1) begin
                e = qa.pop_front();
                mRegWrite = 1; mWReg = e.reg_idx; mWData = e.data; mGranted = 2'b01;
            end else if (g == 2) begin
                e = qb.pop_front();
                mRegWrite = 1; mWReg = e.reg_idx; mWData = e.data; mGranted = 2'b10;
            end else begin
                mRegWrite = 0;
                mGranted = 2'b00;
            end
            if (A_Valid && ra && A_Reg != 0) qa.push_back(mk(int'(A_Reg), A_Data));
            if (B_Valid && rb && B_Reg != 0) qb.push_back(mk(int'(B_Reg), B_Data));
        end
    end

    function automatic logic [NREG-1:0] modelMask();
        logic [NREG-1:0] m;
        m = '0;
        foreach (qa[i]) m[qa[i].reg_idx] = 1'b1;
        foreach (qb[i]) m[qb[i].reg_idx] = 1'b1;
        if (mRegWrite) m[mWReg] = 1'b1;
        m[0] = 1'b0;
        return m;
    endfunction

    // RegisterFile as seen by the DUT's write port.
    always @(posedge Clk) begin
        if (RegWrite) dutRf[WriteRegister] <= WriteData;
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge Clk) begin
        if (checkEn) begin
            check("A_Ready", A_Ready, qa.size() < DEPTH);
            check("B_Ready", B_Ready, qb.size() < DEPTH);
            check("RegWrite", RegWrite, mRegWrite);
            check("Granted", Granted, mGranted);
            check("WriteRegister", WriteRegister, mWReg);
            check("WriteData", WriteData, mWData);
            check("PendingMask", PendingMask, modelMask());
        end
    end

    // ---------------- issue log and observation flags ----------------
    typedef struct {
        logic [1:0]    g;
        logic [AW-1:0] r;
        logic [DW-1:0] d;
        logic          p;
    } issue_t;
    issue_t issueLog[$];
    bit sawBBlocked = 0;
    bit sawBit0 = 0;

    always @(negedge Clk) begin
        issue_t it;
        if (RegWrite) begin
            it.g = Granted; it.r = WriteRegister; it.d = WriteData; it.p = PendingMask[WriteRegister];
            issueLog.push_back(it);
        end
        if (B_Valid && !B_Ready) sawBBlocked = 1;
        if (PendingMask[0]) sawBit0 = 1;
    end

    // ---------------- stimulus driver ----------------
    wr_req_t aStim[$];
    wr_req_t bStim[$];
    int aRate = 100;
    int bRate = 100;

    initial begin : driver
        bit aDone;
        bit bDone;
        forever begin
            @(posedge Clk);
            aDone = A_Valid && A_Ready;
            bDone = B_Valid && B_Ready;
            #2;
            if (aDone && aStim.size() > 0) void'(aStim.pop_front());
            if (bDone && bStim.size() > 0) void'(bStim.pop_front());
            if (!(A_Valid && !aDone)) begin
                if (aStim.size() > 0 && int'($urandom_range(99)) < aRate) begin
                    A_Valid = 1'b1; A_Reg = aStim[0].reg_idx; A_Data = aStim[0].data;
                end else begin
                    A_Valid = 1'b0;
                end
            end
            if (!(B_Valid && !bDone)) begin
                if (bStim.size() > 0 && int'($urandom_range(99)) < bRate) begin
                    B_Valid = 1'b1; B_Reg = bStim[0].reg_idx; B_Data = bStim[0].data;
                end else begin
                    B_Valid = 1'b0;
                end
            end
        end
    end

    task automatic waitIdle(input string name, input int maxCyc);
        int n;
        n = 0;
        while ((aStim.size() > 0 || bStim.size() > 0 || A_Valid || B_Valid ||
                qa.size() > 0 || qb.size() > 0 || mRegWrite) && n < maxCyc) begin
            @(negedge Clk);
            n++;
        end
        @(negedge Clk);
        nTests++;
        if (n >= maxCyc) begin
            nFail++;
            $display("FAIL %s: still busy after %0d cycles, required idle", name, n);
        end
    endtask

    task automatic doReset();
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
    endtask

    // ---------------- directed and random sequences ----------------
    initial begin : main
        logic [DW-1:0] snap [NREG];
        issue_t bOnly[$];
        for (int i = 0; i < NREG; i++) begin
            refRf[i] = '0;
            dutRf[i] = '0;
        end

        // Reset state
        repeat (3) @(negedge Clk);
        check("rst RegWrite", RegWrite, 0);
        check("rst WriteRegister", WriteRegister, 0);
        check("rst WriteData", WriteData, 0);
        check("rst Granted", Granted, 0);
        check("rst PendingMask", PendingMask, 0);
        check("rst A_Ready", A_Ready, 1);
        Reset = 1'b0;

        // 1: single A write, latency and mask window
        aStim.push_back(mk(8, 32'h18));
        @(posedge Clk); @(posedge Clk); @(negedge Clk);
        check("t1 mask8 after accept", PendingMask[8], 1);
        check("t1 RegWrite after accept", RegWrite, 0);
        @(negedge Clk);
        check("t1 RegWrite", RegWrite, 1);
        check("t1 WriteRegister", WriteRegister, 8);
        check("t1 WriteData", WriteData, 32'h18);
        check("t1 Granted", Granted, 2'b01);
        check("t1 mask8 issuing", PendingMask[8], 1);
        @(negedge Clk);
        check("t1 RegWrite done", RegWrite, 0);
        check("t1 mask done", PendingMask, 0);
        check("t1 rf8", dutRf[8], 32'h18);

        // 2: contention alternates A,B starting with A
        waitIdle("t1 idle", 50);
        issueLog.delete();
        for (int i = 0; i < 4; i++) begin
            aStim.push_back(mk(9 + i, 3 * (9 + i)));
            bStim.push_back(mk(16 + i, 3 * (16 + i)));
        end
        waitIdle("t2 idle", 100);
        check("t2 count", issueLog.size(), 8);
        for (int k = 0; k < 8; k++) begin
            if (k < issueLog.size()) begin
                check($sformatf("t2 granted[%0d]", k), issueLog[k].g, (k % 2) ? 2'b10 : 2'b01);
                check($sformatf("t2 reg[%0d]", k), issueLog[k].r, (k % 2) ? 16 + k / 2 : 9 + k / 2);
                check($sformatf("t2 data[%0d]", k), issueLog[k].d, (k % 2) ? 3 * (16 + k / 2) : 3 * (9 + k / 2));
            end
        end
        check("t2 rf9", dutRf[9], 32'h1B);
        check("t2 rf10", dutRf[10], 32'h1E);
        check("t2 rf16", dutRf[16], 32'h30);
        check("t2 rf17", dutRf[17], 32'h33);
        check("t2 model rf12", refRf[12], 32'h24);

        // 3: B floods while A keeps the arbiter busy
        issueLog.delete();
        sawBBlocked = 0;
        for (int i = 0; i < 6; i++) aStim.push_back(mk(1 + i, 32'h100 + i));
        for (int i = 0; i < 4; i++) bStim.push_back(mk(21 + i, 32'h200 + i));
        waitIdle("t3 idle", 100);
        check("t3 B_Ready dropped", sawBBlocked, 1);
        foreach (issueLog[i]) if (issueLog[i].g == 2'b10) bOnly.push_back(issueLog[i]);
        check("t3 B count", bOnly.size(), 4);
        for (int k = 0; k < 4; k++) begin
            if (k < bOnly.size()) begin
                check($sformatf("t3 B reg[%0d]", k), bOnly[k].r, 21 + k);
                check($sformatf("t3 B data[%0d]", k), bOnly[k].d, 32'h200 + k);
            end
        end
        check("t3 total", issueLog.size(), 10);

        // 4: register 0 is accepted and dropped
        issueLog.delete();
        sawBit0 = 0;
        aStim.push_back(mk(0, 32'hDEADBEEF));
        waitIdle("t4 idle", 20);
        repeat (3) @(negedge Clk);
        check("t4 handshake consumed", aStim.size(), 0);
        check("t4 no RegWrite", issueLog.size(), 0);
        check("t4 mask bit0", sawBit0, 0);
        check("t4 rf0", dutRf[0], 0);

        // 5: same register from both sides, pointer reset to A
        doReset();
        issueLog.delete();
        aStim.push_back(mk(20, 32'h11));
        bStim.push_back(mk(20, 32'h22));
        waitIdle("t5 idle", 50);
        check("t5 count", issueLog.size(), 2);
        if (issueLog.size() == 2) begin
            check("t5 first src", issueLog[0].g, 2'b01);
            check("t5 first data", issueLog[0].d, 32'h11);
            check("t5 mask20 while A issues", issueLog[0].p, 1);
            check("t5 second src", issueLog[1].g, 2'b10);
            check("t5 second data", issueLog[1].d, 32'h22);
            check("t5 mask20 while B issues", issueLog[1].p, 1);
        end
        check("t5 mask20 after", PendingMask[20], 0);
        check("t5 rf20", dutRf[20], 32'h22);
        check("t5 model rf20", refRf[20], 32'h22);

        // Random traffic
        for (int blk = 0; blk < 4; blk++) begin
            aRate = int'($urandom_range(100, 30));
            bRate = int'($urandom_range(100, 30));
            for (int i = 0; i < 60; i++) begin
                aStim.push_back(mk(int'($urandom_range(31)), $urandom));
                bStim.push_back(mk(int'($urandom_range(31)), $urandom));
            end
            waitIdle($sformatf("random block %0d idle", blk), 2000);
        end
        aRate = 100;
        bRate = 100;

        // 6: reset with three writes queued
        doReset();
        waitIdle("t6 pre idle", 20);
        for (int i = 0; i < NREG; i++) snap[i] = dutRf[i];
        aStim.push_back(mk(25, 32'hA25));
        aStim.push_back(mk(26, 32'hA26));
        bStim.push_back(mk(27, 32'hB27));
        bStim.push_back(mk(28, 32'hB28));
        @(posedge Clk); @(posedge Clk); @(posedge Clk); @(negedge Clk);
        check("t6 mask before reset", PendingMask & 32'h1E00_0000, 32'h1E00_0000);
        check("t6 RegWrite before reset", RegWrite, 1);
        Reset = 1'b1;
        @(negedge Clk);
        check("t6 RegWrite after reset", RegWrite, 0);
        check("t6 mask after reset", PendingMask, 0);
        issueLog.delete();
        Reset = 1'b0;
        repeat (6) @(negedge Clk);
        check("t6 no writes after reset", issueLog.size(), 0);
        check("t6 rf26", dutRf[26], snap[26]);
        check("t6 rf27", dutRf[27], snap[27]);
        check("t6 rf28", dutRf[28], snap[28]);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
